// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch stage.
// Fetches one 32-bit instruction as four byte reads over a shared byte-wide
// memory port. The bytes are assembled little-endian, and the result is
// presented to the IF/ID register as {pc_o, inst_o, inst_valid_o}.
// A redirect from decode aborts any fetch that is in flight.
//
// Optional feature (macro IF_ALIGN_CHECK_EN):
//   defined   : misaligned redirect targets are word-aligned and misalign_o
//               is set; it stays set until rst.
//   undefined : targets are used as given and misalign_o is tied to 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy_i           global ready; when low, all state is frozen
//   stall_i         downstream not accepting; also blocks redirects
//   branch_en_i     redirect request
//   branch_addr_i   redirect target
//   mem_req_o       byte-read request (combinational)
//   mem_addr_o      byte address of the request (combinational)
//   mem_gnt_i       grant for the current request
//   mem_rdata_i     read byte, valid the cycle after the grant
//   pc_o, inst_o    presented instruction and its pc
//   inst_valid_o    pc_o/inst_o hold a complete instruction
//   misalign_o      sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        stall_i,
  input  logic        branch_en_i,
  input  logic [31:0] branch_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        misalign_o
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_recv_cnt;
  logic               r_pending;
  logic [31:0]        r_pc_o;
  logic [31:0]        r_inst;
  logic               r_valid;

  logic               w_redirect;
  logic               w_req;
  logic               w_grant;
  logic [31:0]        w_target;

  // A redirect is only accepted while running and not stalled.
  assign w_redirect = rdy_i & branch_en_i & ~stall_i;

  // The request is masked in the redirect cycle, so a grant and a redirect
  // never coincide.
  assign w_req   = ~rst & rdy_i & (r_state == S_FETCH) &
                   (r_issue_cnt < CNT_W'(4)) & ~w_redirect;
  assign w_grant = w_req & mem_gnt_i;

`ifdef IF_ALIGN_CHECK_EN
  logic r_misalign;
  assign w_target   = {branch_addr_i[31:2], 2'b00};
  assign misalign_o = r_misalign;
`else
  assign w_target   = branch_addr_i;
  assign misalign_o = 1'b0;
`endif

  assign mem_req_o    = w_req;
  assign mem_addr_o   = rst ? 32'h0 : (r_pc + 32'(r_issue_cnt));
  assign pc_o         = r_pc_o;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;

  // Fetch/hold sequencing, byte assembly and redirect handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_pending   <= 1'b0;
      r_pc_o      <= RESET_PC;
      r_inst      <= '0;
      r_valid     <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      r_misalign  <= 1'b0;
`endif
    end else if (rdy_i) begin
      if (w_redirect) begin
        // Any byte still pending from the previous grant is dropped.
        r_state     <= S_FETCH;
        r_pc        <= w_target;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_pending   <= 1'b0;
        r_valid     <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        if (branch_addr_i[1:0] != 2'b00) r_misalign <= 1'b1;
`endif
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_grant) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            r_pending <= w_grant;
            if (r_pending) begin
              r_inst[{r_recv_cnt[1:0], 3'b000} +: 8] <= mem_rdata_i;
              r_recv_cnt <= r_recv_cnt + CNT_W'(1);
              if (r_recv_cnt == CNT_W'(3)) begin
                r_state <= S_HOLD;
                r_valid <= 1'b1;
                r_pc_o  <= r_pc;
              end
            end
          end
          S_HOLD: begin
            if (!stall_i) begin
              r_state     <= S_FETCH;
              r_valid     <= 1'b0;
              r_pc        <= r_pc + 32'd4;
              r_issue_cnt <= '0;
              r_recv_cnt  <= '0;
              r_pending   <= 1'b0;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_i;
  logic        stall_i;
  logic        branch_en_i;
  logic [31:0] branch_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy_i(rdy_i), .stall_i(stall_i),
    .branch_en_i(branch_en_i), .branch_addr_i(branch_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // Byte memory: data returned the cycle after a granted request.
  always @(posedge clk) begin
    if (mem_req_o && mem_gnt_i) mem_rdata_i <= mem[mem_addr_o[7:0]];
  end

  // Reference model: one instruction = four little-endian bytes at pc..pc+3.
  logic [31:0] m_pc, m_pco, m_inst;
  int          m_issued, m_recvd;
  bit          m_pend, m_hold, m_valid, m_mis;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pco = 32'h0; m_inst = 32'h0;
    m_issued = 0; m_recvd = 0;
    m_pend = 0; m_hold = 0; m_valid = 0; m_mis = 0;
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input bit r, input bit rd, input bit st, input bit br,
                      input logic [31:0] ba, input bit g, input bit do_chk);
    bit redir, e_req;
    @(negedge clk);
    rst = r; rdy_i = rd; stall_i = st; branch_en_i = br;
    branch_addr_i = ba; mem_gnt_i = g;
    #1;
    redir = rd && br && !st;
    e_req = !r && rd && !m_hold && (m_issued < 4) && !redir;
    if (do_chk) begin
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      if (e_req) chk("mem_addr", mem_addr_o, m_pc + 32'(m_issued));
      chk("valid", 32'(inst_valid_o), 32'(m_valid));
      chk("pc_o", pc_o, m_pco);
      if (m_valid) chk("inst", inst_o, m_inst);
      chk("misalign", 32'(misalign_o), 32'(m_mis));
    end
    if (r) model_reset();
    else if (rd) begin
      if (redir) begin
`ifdef IF_ALIGN_CHECK_EN
        m_pc = ba & 32'hFFFF_FFFC;
        if (ba[1:0] != 2'b00) m_mis = 1;
`else
        m_pc = ba;
`endif
        m_issued = 0; m_recvd = 0; m_pend = 0; m_valid = 0; m_hold = 0;
      end else if (!m_hold) begin
        if (m_pend) begin
          m_inst[m_recvd*8 +: 8] = mem_rdata_i;
          m_recvd++;
          if (m_recvd == 4) begin
            m_hold = 1; m_valid = 1; m_pco = m_pc;
          end
        end
        m_pend = e_req && g;
        if (m_pend) m_issued++;
      end else if (!st) begin
        m_pc = m_pc + 32'd4;
        m_issued = 0; m_recvd = 0; m_pend = 0; m_valid = 0; m_hold = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
    mem_rdata_i = 8'h0;
    model_reset();

    // Reset, then a straight fetch with grant every cycle.
    step(1, 1, 0, 0, 32'h0, 1, 0);
    step(1, 1, 0, 0, 32'h0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 32'h0, 1, 1);
      chk("d_addr", mem_addr_o, 32'(k));
    end
    step(0, 1, 0, 0, 32'h0, 1, 1);
    chk("d_valid_late", 32'(inst_valid_o), 32'h0);
    step(0, 1, 0, 0, 32'h0, 1, 1);
    chk("d_valid", 32'(inst_valid_o), 32'h1);
    chk("d_inst", inst_o, 32'h0050_0093);
    chk("d_pc", pc_o, 32'h0);
    step(0, 1, 0, 0, 32'h0, 1, 1);
    chk("d_next_addr", mem_addr_o, 32'h4);
    chk("d_next_valid", 32'(inst_valid_o), 32'h0);

    // Misaligned redirect straight after reset.
    step(1, 1, 0, 0, 32'h0, 0, 1);
    step(0, 1, 0, 1, 32'h102, 1, 1);
    step(0, 1, 0, 0, 32'h0, 1, 1);
`ifdef IF_ALIGN_CHECK_EN
    chk("d_align_addr", mem_addr_o, 32'h100);
    chk("d_misalign", 32'(misalign_o), 32'h1);
`else
    chk("d_align_addr", mem_addr_o, 32'h102);
    chk("d_misalign", 32'(misalign_o), 32'h0);
`endif

    // Randomized traffic: grant gaps, stalls, freezes, redirects, resets,
    // and a redirect near the top of the address space to exercise wrap.
    for (int n = 0; n < 3000; n++) begin
      bit          r, rd, st, br, g;
      logic [31:0] ba;
      r  = ($urandom_range(0, 299) == 0);
      rd = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 9) < 3);
      br = ($urandom_range(0, 24) == 0);
      g  = ($urandom_range(0, 9) < 7);
      ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                       : 32'($urandom_range(0, 255));
      step(r, rd, st, br, ba, g, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
